// File: rtl/regfile_mp_sb.sv
// Parametrised multi-read-port register file with write-first bypass, per-register
// pending-write scoreboard and a one-entry-per-cycle clear engine.
module regfile_mp_sb #(
  parameter  int XLEN     = 32,
  parameter  int NREGS    = 32,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NRD*AW-1:0]   i_rs_addr,
  output logic [NRD*XLEN-1:0] o_rs_data,
  output logic [NRD-1:0]      o_rs_busy,
  input  logic [AW-1:0]       i_rd_addr,
  input  logic                i_rd_wren,
  input  logic [XLEN-1:0]     i_rd_data,
  input  logic                i_issue_valid,
  input  logic [AW-1:0]       i_issue_rd,
  input  logic                i_clear,
  output logic                o_ready
);

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

  state_t              state;
  logic                ready;
  logic [AW-1:0]       cnt;
  logic [NREGS-1:0]    pending;
  logic [XLEN-1:0]     mem [NREGS];

  logic                wr_ok, iss_ok;
  logic                mem_we;
  logic [AW-1:0]       mem_wa;
  logic [XLEN-1:0]     mem_wd;
  logic [AW-1:0]       a;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;

  assign wr_ok  = i_rd_wren && !(ZERO_REG != 0 && i_rd_addr == '0);
  assign iss_ok = i_issue_valid && !(ZERO_REG != 0 && i_issue_rd == '0);

  // Single write port shared by the clear engine and writeback keeps the array RAM-mappable.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = i_rd_addr;
    mem_wd = i_rd_data;
    if (state == CLEAR) begin
      mem_we = 1'b1;
      mem_wa = cnt;
      mem_wd = '0;
    end else begin
      mem_we = wr_ok && !i_clear;
    end
    if (i_reset) mem_we = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= CLEAR;
      ready   <= 1'b0;
      cnt     <= '0;
      pending <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (cnt == AW'(NREGS - 1)) begin
            state <= IDLE;
            ready <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        default: begin
          if (i_clear) begin
            state   <= CLEAR;
            ready   <= 1'b0;
            cnt     <= '0;
            pending <= '0;
          end else begin
            // Issue is applied after the write so a new producer wins on the same register.
            if (wr_ok)  pending[i_rd_addr]  <= 1'b0;
            if (iss_ok) pending[i_issue_rd] <= 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    a       = '0;
    for (int k = 0; k < NRD; k++) begin
      a = i_rs_addr[k*AW +: AW];
      if (ready && !(ZERO_REG != 0 && a == '0)) begin
        if (i_rd_wren && i_rd_addr == a) begin
          rd_data[k] = i_rd_data;
          rd_busy[k] = i_issue_valid && i_issue_rd == a;
        end else begin
          rd_data[k] = mem[a];
          rd_busy[k] = pending[a];
        end
      end
    end
  end

  assign o_rs_data = rd_data;
  assign o_rs_busy = rd_busy;
  assign o_ready   = ready;

  always_ff @(posedge i_clk) begin
    if (!i_reset && ready) assert (!$isunknown(o_rs_data));
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: default config checked against a countdown/array reference
// model under directed and random stimulus, plus a 16x64, 3-port, no-zero-reg config.
module tb_regfile_mp_sb;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // config A: 32x32, 2 ports, x0 hardwired
  logic        reset, rd_wren, issue_valid, clear;
  logic [9:0]  rs_addr;
  logic [4:0]  rd_addr, issue_rd;
  logic [31:0] rd_data;
  wire  [63:0] rs_data;
  wire  [1:0]  rs_busy;
  wire         ready;

  // config B: 16x64, 3 ports, x0 ordinary
  logic        b_reset, b_rd_wren, b_issue_valid, b_clear;
  logic [11:0] b_rs_addr;
  logic [3:0]  b_rd_addr, b_issue_rd;
  logic [63:0] b_rd_data;
  wire  [191:0] b_rs_data;
  wire  [2:0]  b_rs_busy;
  wire         b_ready;

  regfile_mp_sb #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1)) dut_a (
    .i_clk(clk), .i_reset(reset), .i_rs_addr(rs_addr), .o_rs_data(rs_data),
    .o_rs_busy(rs_busy), .i_rd_addr(rd_addr), .i_rd_wren(rd_wren), .i_rd_data(rd_data),
    .i_issue_valid(issue_valid), .i_issue_rd(issue_rd), .i_clear(clear), .o_ready(ready));

  regfile_mp_sb #(.XLEN(64), .NREGS(16), .NRD(3), .ZERO_REG(0)) dut_b (
    .i_clk(clk), .i_reset(b_reset), .i_rs_addr(b_rs_addr), .o_rs_data(b_rs_data),
    .o_rs_busy(b_rs_busy), .i_rd_addr(b_rd_addr), .i_rd_wren(b_rd_wren), .i_rd_data(b_rd_data),
    .i_issue_valid(b_issue_valid), .i_issue_rd(b_issue_rd), .i_clear(b_clear), .o_ready(b_ready));

  int passed = 0;
  int total  = 0;

  // Reference model for config A: contents, pending flags, and cycles of clear remaining.
  logic [31:0] m_mem [32];
  bit          m_pend [32];
  int          m_left;
  bit          m_valid = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic m_wipe();
    m_left = 32;
    foreach (m_mem[i]) m_mem[i] = '0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
  endtask

  // Let inputs settle, then compare config A against the model.
  task automatic pre();
    logic [4:0]  ad;
    logic [31:0] ed;
    logic        eb;
    #1;
    if (m_valid) begin
      chk("ready", ready, m_left == 0);
      for (int k = 0; k < 2; k++) begin
        ad = rs_addr[k*5 +: 5];
        ed = '0;
        eb = 1'b0;
        if (m_left == 0 && ad != 0) begin
          if (rd_wren && rd_addr == ad) begin
            ed = rd_data;
            eb = issue_valid && issue_rd == ad;
          end else begin
            ed = m_mem[ad];
            eb = m_pend[ad];
          end
        end
        chk($sformatf("data%0d", k), rs_data[k*32 +: 32], ed);
        chk($sformatf("busy%0d", k), rs_busy[k], eb);
      end
    end
  endtask

  // Clock edge, then advance the model with the inputs the DUT just sampled.
  task automatic post();
    @(posedge clk);
    if (reset) begin
      m_wipe();
      m_valid = 1'b1;
    end else if (m_left > 0) begin
      m_left--;
    end else if (clear) begin
      m_wipe();
    end else begin
      if (rd_wren && rd_addr != 0) begin
        m_mem[rd_addr]  = rd_data;
        m_pend[rd_addr] = 1'b0;
      end
      if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
    end
    #1;
  endtask

  task automatic step();
    pre();
    post();
  endtask

  task automatic idle_a();
    reset = 1'b0; rd_wren = 1'b0; issue_valid = 1'b0; clear = 1'b0;
  endtask

  initial begin
    int low_a, low_b;
    idle_a();
    rs_addr = '0; rd_addr = '0; issue_rd = '0; rd_data = '0;
    b_reset = 1'b0; b_rd_wren = 1'b0; b_issue_valid = 1'b0; b_clear = 1'b0;
    b_rs_addr = '0; b_rd_addr = '0; b_issue_rd = '0; b_rd_data = '0;

    // Reset both, then count ready-low cycles.
    reset = 1'b1; b_reset = 1'b1;
    step();
    reset = 1'b0; b_reset = 1'b0;
    low_a = 0; low_b = 0;
    for (int i = 0; i < 40; i++) begin
      rs_addr = 10'($urandom);
      pre();
      if (!ready) low_a++;
      if (!b_ready) low_b++;
      post();
    end
    chk("rst_low_a", low_a, 32);
    chk("rst_low_b", low_b, 16);

    // Bypass then storage read of x5.
    rd_wren = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEADBEEF; rs_addr = {5'd3, 5'd5};
    pre(); chk("byp_x5", rs_data[31:0], 32'hDEADBEEF); post();
    idle_a();
    pre(); chk("mem_x5", rs_data[31:0], 32'hDEADBEEF); post();

    // Scoreboard on x7.
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    idle_a(); rs_addr = {5'd7, 5'd7};
    pre(); chk("busy_x7", rs_busy, 2'b11); post();
    rd_wren = 1'b1; rd_addr = 5'd7; rd_data = 32'h12345678;
    pre(); chk("wb_busy_x7", rs_busy, 2'b00); chk("wb_data_x7", rs_data[63:32], 32'h12345678); post();
    idle_a();
    pre(); chk("after_busy_x7", rs_busy, 2'b00); post();

    // Issue and write x9 together: new producer keeps it pending.
    rd_wren = 1'b1; rd_addr = 5'd9; rd_data = 32'h1; issue_valid = 1'b1; issue_rd = 5'd9;
    rs_addr = {5'd9, 5'd9};
    step();
    idle_a();
    pre(); chk("x9_data", rs_data[31:0], 32'h1); chk("x9_busy", rs_busy[0], 1'b1); post();

    // x0 ignores writes and issues.
    rd_wren = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFFFFFF; issue_valid = 1'b1; issue_rd = 5'd0;
    rs_addr = '0;
    pre(); chk("x0_byp", rs_data, 64'h0); chk("x0_byp_busy", rs_busy, 2'b00); post();
    idle_a();
    pre(); chk("x0_data", rs_data, 64'h0); chk("x0_busy", rs_busy, 2'b00); post();

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      rd_wren     = 1'($urandom_range(0, 1));
      rd_addr     = 5'($urandom);
      rd_data     = $urandom;
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom);
      clear       = ($urandom_range(0, 49) == 0);
      rs_addr     = ($urandom_range(0, 3) == 0) ? {rd_addr, rd_addr} : 10'($urandom);
      step();
    end
    idle_a();

    // Fill, clear, re-pulse clear mid-way, write during clear.
    for (int r = 1; r < 32; r++) begin
      rd_wren = 1'b1; rd_addr = 5'(r); rd_data = $urandom | 32'h1;
      step();
    end
    idle_a(); clear = 1'b1;
    step();
    clear = 1'b0;
    low_a = 0;
    for (int i = 0; i < 40; i++) begin
      rd_wren = (i < 32); rd_addr = 5'($urandom); rd_data = $urandom | 32'h1;
      issue_valid = (i < 32); issue_rd = 5'($urandom);
      clear = (i == 2);
      rs_addr = 10'($urandom);
      pre();
      if (!ready) low_a++;
      post();
    end
    idle_a();
    chk("clr_low", low_a, 32);
    for (int ad = 0; ad < 32; ad++) begin
      rs_addr = {5'(31 - ad), 5'(ad)};
      pre(); chk("clr_zero", rs_data, 64'h0); chk("clr_busy", rs_busy, 2'b00); post();
    end

    // Reset at cnt = 10 restarts the clear.
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    low_a = 0;
    for (int i = 0; i < 40; i++) begin
      rs_addr = 10'($urandom);
      pre();
      if (!ready) low_a++;
      post();
    end
    chk("rst_mid_low_a", low_a, 32);

    // Config B: register 0 is ordinary.
    b_rd_wren = 1'b1; b_rd_addr = 4'd0; b_rd_data = 64'hA5A5_A5A5_A5A5_A5A5; b_rs_addr = '0;
    pre(); chk("b_byp_x0", b_rs_data[63:0], 64'hA5A5_A5A5_A5A5_A5A5); post();
    b_rd_wren = 1'b0;
    pre();
    for (int k = 0; k < 3; k++)
      chk($sformatf("b_x0_p%0d", k), b_rs_data[k*64 +: 64], 64'hA5A5_A5A5_A5A5_A5A5);
    chk("b_x0_busy0", b_rs_busy, 3'b000);
    post();
    b_issue_valid = 1'b1; b_issue_rd = 4'd0;
    step();
    b_issue_valid = 1'b0;
    pre(); chk("b_x0_busy1", b_rs_busy, 3'b111); post();

    b_clear = 1'b1;
    step();
    b_clear = 1'b0;
    for (int i = 0; i < 10; i++) step();
    b_reset = 1'b1;
    step();
    b_reset = 1'b0;
    low_b = 0;
    for (int i = 0; i < 30; i++) begin
      pre();
      if (!b_ready) low_b++;
      post();
    end
    chk("rst_mid_low_b", low_b, 16);
    pre(); chk("b_x0_cleared", b_rs_data, 192'h0); chk("b_busy_cleared", b_rs_busy, 3'b000); post();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised successor to the RV32I 32x32 register file: configurable width, depth and read-port count.
- Write-first bypass on every read port, plus a per-register pending-write scoreboard for pipeline hazard detection.
- Sequential clear engine zeroes storage one entry per cycle, so the array maps to RAM.
- Sits between decode (issue/read) and writeback in the pipelined core.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of registers (power of 2, >=2); AW = $clog2(NREGS) is a localparam.
- NRD, 2, number of asynchronous read ports.
- ZERO_REG, 1, 1 = register 0 hardwired to zero (writes and issues ignored); 0 = register 0 is ordinary.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  one clock; reset is synchronous and active-high.
- i_rs_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
- o_rs_data  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN].
- o_rs_busy  out  NRD  port k's register has a pending write.
- i_rd_addr  in  AW  write address.
- i_rd_wren  in  1  write enable.
- i_rd_data  in  XLEN  write data.
- i_issue_valid  in  1  mark i_issue_rd pending this cycle.
- i_issue_rd  in  AW  destination register of the issued instruction.
- i_clear  in  1  single-cycle pulse: start a full clear.
- o_ready  out  1  1 = IDLE, array usable.

Behaviour:
- FSM states:
  - CLEAR: writes zero to entry cnt each cycle, cnt increments. When cnt == NREGS-1 the last entry is written and the next state is IDLE.
  - IDLE: normal operation.
- Reset (i_reset=1 at a clock edge): state <= CLEAR, cnt <= 0, all pending bits <= 0. Reset has priority over every other input, including mid-clear, where the clear restarts at 0.
- Timing from reset: after reset deasserts, o_ready = 0 for exactly NREGS cycles, then 1.
- i_clear:
  - In IDLE: enters CLEAR with cnt = 0 and zeroes all pending bits at the same edge. The clear takes NREGS cycles.
  - During CLEAR: ignored.
- During CLEAR:
  - o_rs_data = 0 and o_rs_busy = 0 on all ports.
  - i_rd_wren and i_issue_valid are ignored: no storage or scoreboard change.
- Write (IDLE): at the edge, if i_rd_wren and !(ZERO_REG && i_rd_addr == 0), then mem[i_rd_addr] <= i_rd_data and pending[i_rd_addr] <= 0. A write to a non-pending register is legal.
- Issue (IDLE): at the edge, if i_issue_valid and !(ZERO_REG && i_issue_rd == 0), then pending[i_issue_rd] <= 1.
  - Issue and write to the same register in the same cycle: pending ends 1 (new producer wins); data is still written.
  - Issuing an already-pending register: stays 1.
- Read (combinational, IDLE), port k, with a = addr_k:
  - ZERO_REG && a == 0: data = 0, busy = 0.
  - Else, if i_rd_wren && i_rd_addr == a: data = i_rd_data (bypass) and busy = 0, unless the same cycle issues to a, in which case busy = 1.
  - Else: data = mem[a], busy = pending[a].
- All NRD ports are independent; identical addresses on several ports return identical values.
- Register 0 with ZERO_REG=1: the storage entry may hold anything, but it is never observable.
- No X on outputs after the first clear completes; simulation asserts that o_rs_data has no X/Z when o_ready = 1.

Test Plan:
- Reset, then idle NREGS+2 cycles -> o_ready is 0 for exactly 32 cycles then 1; every read returns 0 and busy = 0.
- Write x5 = 32'hDEADBEEF while port 0 reads x5 in the same cycle -> port 0 returns DEADBEEF combinationally (bypass); the next cycle still returns DEADBEEF from storage.
- Issue x7, then read x7 on ports 0 and 1 -> busy = 2'b11. Write x7 = 32'h12345678 -> same-cycle busy = 0 and data = 12345678; busy stays 0 afterwards.
- Same cycle: issue x9 and write x9 = 32'h1 -> next cycle x9 reads 1 with busy = 1. Write x0 = 32'hFFFFFFFF and issue x0 -> x0 reads 0, busy 0.
- Fill x1..x31 with nonzero values, pulse i_clear, and pulse i_clear again 3 cycles later -> o_ready is low for exactly 32 cycles (the second pulse is ignored); writes during the clear are discarded; all registers read 0 afterwards.
- Assert i_reset at cnt = 10 of a clear -> the clear restarts and o_ready rises 32 cycles after reset deasserts. Repeat with NREGS=16, XLEN=64, NRD=3, ZERO_REG=0 -> register 0 is writable and reads back 64'hA5A5_A5A5_A5A5_A5A5 on all 3 ports.
